// File: rtl/line_clear_engine_if.sv
// Row-wide board RAM port: one synchronous read port (1-cycle latency) and one write port.
interface line_clear_engine_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 30
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/line_clear_engine.sv
// Line-clear and compaction engine: scans the board bottom-up, drops full rows,
// shifts the remaining rows down and back-fills the top with empty rows.
module line_clear_engine #(
  parameter int unsigned BOARD_WIDTH  = 10,
  parameter int unsigned BOARD_HEIGHT = 30,
  parameter int unsigned CELL_BITS    = 3,
  parameter int unsigned BUFFER_ROWS  = 10,
  localparam int unsigned CW = $clog2(BOARD_HEIGHT + 1),
  localparam int unsigned AW = $clog2(BOARD_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [CW-1:0]           lines_cleared,
  output logic [BOARD_HEIGHT-1:0] cleared_mask,
  output logic                    top_out,
  line_clear_engine_if.master     ram
);
  localparam int unsigned DW = BOARD_WIDTH * CELL_BITS;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CHK, S_FILL, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           src_q, src_d, dst_q, dst_d, rd_addr_q, rd_addr_d;
  logic [CW-1:0]           cnt_q, cnt_d, lines_q, lines_d;
  logic [BOARD_HEIGHT-1:0] mask_q, mask_d;
  logic                    top_q, top_d, busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic                    full_c, empty_c, wr_en_c;
  logic [AW-1:0]           wr_addr_c;
  logic [DW-1:0]           wr_data_c;

  // Row classification of the word returned by the RAM this cycle.
  always_comb begin
    full_c = 1'b1;
    for (int i = 0; i < int'(BOARD_WIDTH); i++) begin
      if (ram.rd_data[i*CELL_BITS +: CELL_BITS] == '0) full_c = 1'b0;
    end
    empty_c = (ram.rd_data == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      lines_q   <= '0;
      mask_q    <= '0;
      top_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      lines_q   <= lines_d;
      mask_q    <= mask_d;
      top_q     <= top_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Writes happen in the cycle the row is checked so they never collide with a read.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    lines_d   = lines_q;
    mask_d    = mask_q;
    top_d     = top_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_c   = 1'b0;
    wr_addr_c = '0;
    wr_data_c = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = AW'(BOARD_HEIGHT - 1);
          dst_d   = AW'(BOARD_HEIGHT - 1);
          cnt_d   = '0;
          lines_d = '0;
          mask_d  = '0;
          top_d   = 1'b0;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_CHK;
      S_CHK: begin
        if (full_c) begin
          cnt_d         = cnt_q + CW'(1);
          mask_d[src_q] = 1'b1;
        end else begin
          if (src_q != dst_q) begin
            wr_en_c   = 1'b1;
            wr_addr_c = dst_q;
            wr_data_c = ram.rd_data;
          end
          if (!empty_c && (32'(dst_q) < BUFFER_ROWS)) top_d = 1'b1;
          if (dst_q != '0) dst_d = dst_q - AW'(1);
        end
        if (src_q == '0) begin
          state_d = (cnt_d != '0) ? S_FILL : S_DONE;
        end else begin
          src_d   = src_q - AW'(1);
          state_d = S_RD;
        end
      end
      S_FILL: begin
        wr_en_c   = 1'b1;
        wr_addr_c = dst_q;
        if (dst_q == '0) state_d = S_DONE;
        else             dst_d   = dst_q - AW'(1);
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_RD) begin
      rd_en_d   = 1'b1;
      rd_addr_d = src_d;
    end
    if (state_d == S_DONE) lines_d = cnt_d;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = lines_q;
  assign cleared_mask  = mask_q;
  assign top_out       = top_q;
  assign ram.rd_en     = rd_en_q;
  assign ram.rd_addr   = rd_addr_q;
  assign ram.wr_en     = wr_en_c;
  assign ram.wr_addr   = wr_addr_c;
  assign ram.wr_data   = wr_data_c;
endmodule
